// File: rtl/manual_trigger_pkg.sv
// Shared encodings for the manual trigger block: edge selection, output modes,
// and small helpers used by the per-channel debouncer and the output stage.
package manual_trigger_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_SINGLE  = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Reserved encoding behaves exactly like single-pulse mode.
  function automatic mode_e eff_mode(input mode_e m);
    return (m == MODE_RSVD) ? MODE_SINGLE : m;
  endfunction

  // new_level is the level the debounced signal is switching to.
  function automatic logic edge_ok(input logic [1:0] sel, input logic new_level);
    case (sel)
      EDGE_RISE: return new_level;
      EDGE_FALL: return ~new_level;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/trig_debounce.sv
// One trigger channel: 2-flop synchronizer, saturating debounce counter and
// edge qualification producing a registered one-cycle event strobe.
module trig_debounce
  import manual_trigger_pkg::*;
#(
  parameter int DEB_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_trig,
  input  logic [1:0]       i_edge_sel,
  input  logic [DEB_W-1:0] i_deb_len,
  output logic             o_edge_evt
);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [DEB_W-1:0] r_cnt;
  logic             r_evt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_evt    <= 1'b0;
    end else begin
      r_s1  <= i_trig;
      r_s2  <= r_s1;
      r_evt <= 1'b0;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt < i_deb_len) begin
        r_cnt <= r_cnt + DEB_W'(1);
      end else begin
        // Also covers Deb_len lowered below a running count: accept at once.
        r_stable <= r_s2;
        r_cnt    <= '0;
        r_evt    <= edge_ok(i_edge_sel, r_s2);
      end
    end
  end

  assign o_edge_evt = r_evt;

endmodule

// File: rtl/manual_trigger_multi.sv
// Multi-channel manual trigger: per-channel debounce/edge detect plus a shared
// output stage implementing toggle, single-pulse and stretched-pulse modes.
module manual_trigger_multi
  import manual_trigger_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DEB_W = 8,
  parameter int PW_W  = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             EN,
  input  logic [CH-1:0]    Trig_in,
  input  logic [1:0]       Edge_sel,
  input  logic [1:0]       Mode,
  input  logic [DEB_W-1:0] Deb_len,
  input  logic [PW_W-1:0]  Pulse_len,
  output logic [CH-1:0]    Trig_out,
  output logic [CH-1:0]    Edge_evt,
  output logic [CH-1:0]    Busy
);

  logic [CH-1:0]   w_evt;
  mode_e           w_eff;
  logic            w_mode_chg;
  logic [PW_W-1:0] w_pulse_load;

  mode_e           r_mode;
  logic [CH-1:0]   r_trig;
  logic [CH-1:0]   r_busy;
  logic [PW_W-1:0] r_pcnt [CH];

  for (genvar g = 0; g < CH; g++) begin : g_ch
    trig_debounce #(
      .DEB_W(DEB_W)
    ) u_deb (
      .i_clk     (Clock),
      .i_rst_n   (Reset_n),
      .i_en      (EN),
      .i_trig    (Trig_in[g]),
      .i_edge_sel(Edge_sel),
      .i_deb_len (Deb_len),
      .o_edge_evt(w_evt[g])
    );
  end

  assign w_eff        = eff_mode(r_mode);
  assign w_mode_chg   = (Mode != r_mode);
  assign w_pulse_load = (Pulse_len == '0) ? PW_W'(1) : Pulse_len;

  always_ff @(posedge Clock) begin
    if (!Reset_n || !EN) begin
      r_mode <= MODE_TOGGLE;
      r_trig <= '0;
      r_busy <= '0;
      for (int i = 0; i < CH; i++) r_pcnt[i] <= '0;
    end else begin
      r_mode <= mode_e'(Mode);
      if (w_mode_chg) begin
        // A mode switch aborts everything; events arriving now are dropped.
        r_trig <= '0;
        r_busy <= '0;
        for (int i = 0; i < CH; i++) r_pcnt[i] <= '0;
      end else begin
        for (int i = 0; i < CH; i++) begin
          case (w_eff)
            MODE_TOGGLE: begin
              if (w_evt[i]) r_trig[i] <= ~r_trig[i];
              r_busy[i] <= 1'b0;
              r_pcnt[i] <= '0;
            end
            MODE_STRETCH: begin
              if (r_busy[i]) begin
                // Running pulse ignores new events; counter stops at zero.
                if (r_pcnt[i] <= PW_W'(1)) begin
                  r_trig[i] <= 1'b0;
                  r_busy[i] <= 1'b0;
                  r_pcnt[i] <= '0;
                end else begin
                  r_pcnt[i] <= r_pcnt[i] - PW_W'(1);
                end
              end else if (w_evt[i]) begin
                r_trig[i] <= 1'b1;
                r_busy[i] <= 1'b1;
                r_pcnt[i] <= w_pulse_load;
              end else begin
                r_trig[i] <= 1'b0;
              end
            end
            default: begin
              r_trig[i] <= w_evt[i];
              r_busy[i] <= 1'b0;
              r_pcnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign Trig_out = r_trig;
  assign Busy     = r_busy;
  assign Edge_evt = w_evt;

endmodule

// File: tb/tb_manual_trigger_multi.sv
// Directed bench for manual_trigger_multi: debounce latency, glitch rejection,
// toggle/single/stretched output modes, reset/enable aborts and mode changes.
module tb_manual_trigger_multi;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] trig_in;
  logic [1:0] edge_sel;
  logic [1:0] mode;
  logic [7:0] deb_len;
  logic [7:0] pulse_len;
  logic [3:0] trig_out;
  logic [3:0] edge_evt;
  logic [3:0] busy;

  int checks = 0;
  int errors = 0;

  manual_trigger_multi #(
    .CH(4), .DEB_W(8), .PW_W(8)
  ) dut (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .EN       (en),
    .Trig_in  (trig_in),
    .Edge_sel (edge_sel),
    .Mode     (mode),
    .Deb_len  (deb_len),
    .Pulse_len(pulse_len),
    .Trig_out (trig_out),
    .Edge_evt (edge_evt),
    .Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] m_out;
  logic [15:0] m_busy;
  logic [15:0] m_evt;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    trig_in   = 4'hF;
    edge_sel  = 2'b00;
    mode      = 2'b00;
    deb_len   = 8'd0;
    pulse_len = 8'd5;
    ticks(3);
    check("reset_trig_out", trig_out, 4'h0);
    check("reset_edge_evt", edge_evt, 4'h0);
    check("reset_busy", busy, 4'h0);
    trig_in = 4'h0;
    rst_n   = 1'b1;
    ticks(3);

    // Deb_len=0 toggle/rise: event 3 edges after change, output one later.
    trig_in[0] = 1'b1;
    tick(); check("lat_evt_e1", edge_evt, 4'h0);
    tick(); check("lat_evt_e2", edge_evt, 4'h0);
    tick(); check("lat_evt_e3", edge_evt, 4'h1);
    check("lat_out_e3", trig_out, 4'h0);
    tick(); check("lat_evt_e4", edge_evt, 4'h0);
    check("lat_out_e4", trig_out, 4'h1);
    trig_in[0] = 1'b0;
    m_evt = '0;
    for (int i = 1; i <= 6; i++) begin tick(); m_evt[i] = |edge_evt; end
    check("fall_unqualified_evt", m_evt, 16'h0);
    check("fall_unqualified_out", trig_out, 4'h1);
    trig_in[0] = 1'b1;
    ticks(3); check("toggle2_evt", edge_evt, 4'h1);
    tick();   check("toggle2_out", trig_out, 4'h0);

    // Deb_len=3: 3-cycle glitch rejected on ch1.
    deb_len    = 8'd3;
    trig_in[1] = 1'b1;
    m_evt = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      m_evt[i] = edge_evt[1];
      if (i == 3) trig_in[1] = 1'b0;
    end
    check("glitch_evt", m_evt, 16'h0);
    check("glitch_out", trig_out, 4'h0);

    // 4-cycle pulse: rise at edge 6, then both-edge select catches fall at 10.
    trig_in[1] = 1'b1;
    m_evt = '0;
    m_out = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      m_evt[i] = edge_evt[1];
      m_out[i] = trig_out[1];
      if (i == 4) begin
        trig_in[1] = 1'b0;
        edge_sel   = 2'b10;
      end
    end
    check("deb4_evt_mask", m_evt, 16'h0440);
    check("deb4_out_mask", m_out, 16'h0780);

    // Stretched, Pulse_len=5, fall event 2 cycles later ignored, Pulse_len edited mid-pulse.
    deb_len = 8'd0;
    mode    = 2'b10;
    ticks(3);
    trig_in[2] = 1'b1;
    m_evt = '0; m_out = '0; m_busy = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      m_evt[i]  = edge_evt[2];
      m_out[i]  = trig_out[2];
      m_busy[i] = busy[2];
      if (i == 2) trig_in[2] = 1'b0;
      if (i == 5) pulse_len = 8'd2;
    end
    check("stretch_evt_mask", m_evt, 16'h0028);
    check("stretch_out_mask", m_out, 16'h01F0);
    check("stretch_busy_mask", m_busy, 16'h01F0);

    // Pulse_len=0 yields a single-cycle stretched pulse.
    pulse_len  = 8'd0;
    trig_in[2] = 1'b1;
    m_out = '0; m_busy = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      m_out[i]  = trig_out[2];
      m_busy[i] = busy[2];
    end
    check("plen0_out_mask", m_out, 16'h0010);
    check("plen0_busy_mask", m_busy, 16'h0010);

    // Reset mid-pulse, then re-debounce of held-high inputs after release.
    pulse_len  = 8'd5;
    trig_in[3] = 1'b1;
    ticks(3); check("rst_pre_evt", edge_evt, 4'h8);
    tick();   check("rst_pre_out", trig_out, 4'h8);
    check("rst_pre_busy", busy, 4'h8);
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_out", trig_out, 4'h0);
    check("rst_mid_busy", busy, 4'h0);
    check("rst_mid_evt", edge_evt, 4'h0);
    rst_n = 1'b1;
    tick(); check("rst_rel_out", trig_out, 4'h0);
    tick(); check("rst_rel_evt_e2", edge_evt, 4'h0);
    tick(); check("rst_rel_evt_e3", edge_evt, 4'hD);
    tick(); check("rst_rel_out_e4", trig_out, 4'hD);
    check("rst_rel_busy_e4", busy, 4'hD);
    tick();
    en = 1'b0;
    tick();
    check("en_mid_out", trig_out, 4'h0);
    check("en_mid_busy", busy, 4'h0);
    en = 1'b1;
    ticks(3); check("en_rel_evt", edge_evt, 4'hD);
    tick();   check("en_rel_out_first", trig_out, 4'hD);
    ticks(4); check("en_rel_out_last", trig_out, 4'hD);
    tick();   check("en_rel_out_end", trig_out, 4'h0);
    check("en_rel_busy_end", busy, 4'h0);

    // Edge_sel=11 suppresses every event.
    edge_sel = 2'b11;
    trig_in  = 4'h0;
    m_evt = '0;
    for (int i = 1; i <= 6; i++) begin tick(); m_evt[i] = |edge_evt; end
    check("edge_none_evt", m_evt, 16'h0);

    // Single-pulse mode, all channels at once.
    edge_sel = 2'b00;
    mode     = 2'b01;
    ticks(3);
    trig_in = 4'hF;
    ticks(3); check("all_evt", edge_evt, 4'hF);
    tick();   check("all_single_out", trig_out, 4'hF);
    tick();   check("all_single_end", trig_out, 4'h0);

    // Mode change mid stretched pulse clears outputs.
    mode    = 2'b10;
    trig_in = 4'h0;
    ticks(3);
    trig_in = 4'hF;
    ticks(4); check("mchg_pre_out", trig_out, 4'hF);
    check("mchg_pre_busy", busy, 4'hF);
    tick();
    mode = 2'b01;
    tick();
    check("mchg_out", trig_out, 4'h0);
    check("mchg_busy", busy, 4'h0);
    tick();   check("mchg_after_out", trig_out, 4'h0);

    // Reserved mode behaves as single pulse; falling edges selected.
    mode     = 2'b11;
    edge_sel = 2'b01;
    ticks(3);
    trig_in = 4'h0;
    ticks(3); check("rsvd_evt", edge_evt, 4'hF);
    tick();   check("rsvd_out", trig_out, 4'hF);
    check("rsvd_busy", busy, 4'h0);
    tick();   check("rsvd_end", trig_out, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/manual_trigger_multi.md
MANUAL_TRIGGER_MULTI -- requirements
Module: manual_trigger_multi

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent trigger channels (1..16).
REQ-002 SHALL have parameter DEB_W, default 8, debounce-length field and counter width.
REQ-003 SHALL have parameter PW_W, default 8, pulse-length field and counter width.
REQ-004 SHALL have port Clock  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_n  in  1  one clock; reset is synchronous and active-low.
REQ-006 SHALL have port EN  in  1  block enable; low clears all state like reset.
REQ-007 SHALL have port Trig_in  in  CH  asynchronous manual trigger inputs, one per channel.
REQ-008 SHALL have port Edge_sel  in  2  00 rise, 01 fall, 10 both, 11 none (all channels).
REQ-009 SHALL have port Mode  in  2  00 toggle, 01 single pulse, 10 stretched pulse, 11 reserved (treated as 01).
REQ-010 SHALL have port Deb_len  in  DEB_W  required stable cycles minus one.
REQ-011 SHALL have port Pulse_len  in  PW_W  stretched-pulse high time in cycles; 0 treated as 1.
REQ-012 SHALL have port Trig_out  out  CH  registered trigger outputs.
REQ-013 SHALL have port Edge_evt  out  CH  registered one-cycle strobe per qualified edge.
REQ-014 SHALL have port Busy  out  CH  high while a stretched pulse is in progress.

Function
REQ-015 Each channel SHALL pass Trig_in through a 2-flop synchronizer (s1, s2).
REQ-016 Debounce SHALL keep register stable and counter cnt; s2==stable -> cnt<=0; s2!=stable and cnt<Deb_len -> cnt<=cnt+1; s2!=stable and cnt==Deb_len -> stable<=s2, cnt<=0.
REQ-017 Edge_evt SHALL assert on the same edge stable changes, qualified by Edge_sel; 11 never asserts.
REQ-018 Latency: Trig_in change set up before edge k -> Edge_evt high after edge k+2+Deb_len, Trig_out responds after edge k+3+Deb_len.
REQ-019 Glitch shorter than Deb_len+1 cycles at s2 SHALL produce no event and no output change.
REQ-020 Toggle mode: each Edge_evt SHALL invert Trig_out on the next edge.
REQ-021 Single-pulse mode: each Edge_evt SHALL drive Trig_out high for exactly one cycle.
REQ-022 Stretched mode: Edge_evt with Busy low SHALL load pulse counter and hold Trig_out and Busy high for max(Pulse_len,1) cycles, then both low.
REQ-023 Stretched mode: Edge_evt while Busy SHALL be ignored (no retrigger, no extension); Edge_evt still strobes.
REQ-024 Pulse_len SHALL be sampled only at pulse start; later changes do not affect a running pulse.
REQ-025 Mode change (registered Mode differs from previous cycle) SHALL clear Trig_out, Busy and pulse counter in all channels on that edge; events on that edge are dropped.
REQ-026 Edge_sel change SHALL take effect on the next edge; debounce state unaffected.
REQ-027 Channels SHALL be fully independent; simultaneous events on multiple channels all serviced same cycle.
REQ-028 Counters SHALL not wrap: cnt saturates at Deb_len, pulse counter stops at zero.

Reset
REQ-029 Reset_n low at a rising edge SHALL clear s1, s2, stable, cnt, pulse counter, Trig_out, Edge_evt, Busy to 0; Reset_n has priority over EN.
REQ-030 EN low SHALL apply the same clearing; reset or EN low mid-pulse aborts the pulse immediately.
REQ-031 After release with Trig_in held high, the channel SHALL debounce and report a rising edge (stable resets to 0).

Structure
REQ-032 Package manual_trigger_pkg SHALL hold Edge_sel and Mode encodings as named constants.
REQ-033 Sub-module trig_debounce (sync + debounce + edge qualify, one channel) SHALL be instantiated CH times; output/mode logic resides in the top.

Verification
REQ-034 Deb_len=0, toggle, rise: ch0 0->1 before edge 10 -> Edge_evt[0] high cycle after edge 12, Trig_out[0]=1 after edge 13.
REQ-035 Deb_len=3: 3-cycle high glitch on ch1 -> no Edge_evt; 4-cycle high -> one rise event, and with Edge_sel=10 the fall also strobes.
REQ-036 Stretched, Pulse_len=5: event at cycle T -> Trig_out/Busy high exactly 5 cycles; second event at T+2 ignored.
REQ-037 Pulse_len=0, stretched -> 1-cycle pulse; Pulse_len changed 5->2 mid-pulse -> pulse stays 5.
REQ-038 Stretched pulse running, Reset_n low one cycle at T+2 -> Trig_out, Busy 0 after that edge; same with EN low.
REQ-039 All CH channels edge simultaneously, Mode=01 -> every Trig_out bit high same single cycle; Mode change mid-pulse -> outputs cleared.
